// File: rtl/cipher_job_arbiter_pkg.sv
// Shared widths, FSM state encoding and in-flight tag layout for the cipher job arbiter.
package cipher_ctrl_pkg;

    localparam int unsigned BLK_W = 64;
    localparam int unsigned KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        KEYSET = 2'd2
    } state_t;

    typedef struct packed {
        logic vld;
        logic id;
        logic mode;
    } tag_t;

endpackage

// File: rtl/cipher_job_arbiter_if.sv
// Requester, core and response signals of the cipher job arbiter; slave is the arbiter's view.
interface cipher_job_arbiter_if;
    import cipher_ctrl_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic             req0_mode;
    logic [BLK_W-1:0] req0_data;
    logic [KEY_W-1:0] req0_key;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_mode;
    logic [BLK_W-1:0] req1_data;
    logic [KEY_W-1:0] req1_key;

    logic [BLK_W-1:0] core_din;
    logic [KEY_W-1:0] core_key;
    logic             core_enc_vld;
    logic             core_dec_vld;
    logic [BLK_W-1:0] core_enc_dout;
    logic [BLK_W-1:0] core_dec_dout;

    logic             rsp0_valid;
    logic [BLK_W-1:0] rsp0_data;
    logic             rsp1_valid;
    logic [BLK_W-1:0] rsp1_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_mode, req0_data, req0_key,
        input  req1_valid, req1_mode, req1_data, req1_key,
        input  core_enc_dout, core_dec_dout,
        output req0_ready, req1_ready,
        output core_din, core_key, core_enc_vld, core_dec_vld,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );

    modport master (
        output req0_valid, req0_mode, req0_data, req0_key,
        output req1_valid, req1_mode, req1_data, req1_key,
        output core_enc_dout, core_dec_dout,
        input  req0_ready, req1_ready,
        input  core_din, core_key, core_enc_vld, core_dec_vld,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );

endinterface

// File: rtl/cipher_job_arbiter_tag_pipe.sv
// Fixed-depth shift register of job tags; exposes the oldest stage and an any-valid flag.
module cipher_tag_pipe
    import cipher_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 9
) (
    input  logic clk,
    input  logic clr,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_any
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    always_comb begin
        o_any = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) o_any = o_any | r_stage[i].vld;
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/cipher_job_arbiter.sv
// Round-robin sharing of one encrypt and one decrypt core between two requesters, with key reload.
// Optional CIPHER_STATS_EN adds saturating accept / key-load counters.
module cipher_job_arbiter
    import cipher_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned KEY_SETUP = 2
) (
    input  logic clk,
    input  logic clr,
    cipher_job_arbiter_if.slave bus
`ifdef CIPHER_STATS_EN
    ,
    output logic [15:0] stat_jobs0,
    output logic [15:0] stat_jobs1,
    output logic [15:0] stat_keyloads
`endif
);

    localparam logic [3:0] KS_LAST = 4'(KEY_SETUP - 1);

    state_t           r_state;
    logic             r_last_grant;
    logic [KEY_W-1:0] r_cur_key;
    logic [KEY_W-1:0] r_pend_key;
    logic             r_key_loaded;
    logic [3:0]       r_cnt;
    logic [BLK_W-1:0] r_core_din;
    logic [KEY_W-1:0] r_core_key;
    logic             r_enc_vld;
    logic             r_dec_vld;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [BLK_W-1:0] r_rsp0_data;
    logic [BLK_W-1:0] r_rsp1_data;

    logic             w_gnt0;
    logic             w_gnt1;
    logic [KEY_W-1:0] w_gkey;
    logic             w_key_ok;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_acc;
    logic             w_acc_mode;
    logic [BLK_W-1:0] w_acc_data;
    tag_t             w_tag_in;
    tag_t             w_tag_out;
    logic             w_tag_any;
    logic [BLK_W-1:0] w_result;

    // Under contention the requester that did not win last time is granted.
    assign w_gnt0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_gnt1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_gkey   = w_gnt1 ? bus.req1_key : bus.req0_key;
    assign w_key_ok = r_key_loaded && (w_gkey == r_cur_key);

    assign w_rdy0     = (r_state == IDLE) && w_gnt0 && w_key_ok;
    assign w_rdy1     = (r_state == IDLE) && w_gnt1 && w_key_ok;
    assign w_acc0     = bus.req0_valid && w_rdy0;
    assign w_acc1     = bus.req1_valid && w_rdy1;
    assign w_acc      = w_acc0 || w_acc1;
    assign w_acc_mode = w_acc1 ? bus.req1_mode : bus.req0_mode;
    assign w_acc_data = w_acc1 ? bus.req1_data : bus.req0_data;
    assign w_tag_in   = '{vld: w_acc, id: w_acc1, mode: w_acc_mode};
    assign w_result   = w_tag_out.mode ? bus.core_dec_dout : bus.core_enc_dout;

    cipher_tag_pipe #(
        .DEPTH (LATENCY + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .clr   (clr),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out),
        .o_any (w_tag_any)
    );

    // Key reload: drain in-flight jobs, present the new key, hold it KEY_SETUP cycles.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= IDLE;
            r_cur_key    <= '0;
            r_pend_key   <= '0;
            r_key_loaded <= 1'b0;
            r_cnt        <= '0;
            r_core_key   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if ((w_gnt0 || w_gnt1) && !w_key_ok) begin
                        r_pend_key <= w_gkey;
                        r_state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_tag_any) begin
                        r_core_key <= r_pend_key;
                        r_cnt      <= '0;
                        r_state    <= KEYSET;
                    end
                end
                KEYSET: begin
                    if (r_cnt == KS_LAST) begin
                        r_cur_key    <= r_pend_key;
                        r_key_loaded <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_last_grant <= 1'b1;
            r_core_din   <= '0;
            r_enc_vld    <= 1'b0;
            r_dec_vld    <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_enc_vld    <= w_acc && !w_acc_mode;
            r_dec_vld    <= w_acc && w_acc_mode;
            r_rsp0_valid <= w_tag_out.vld && !w_tag_out.id;
            r_rsp1_valid <= w_tag_out.vld && w_tag_out.id;
            if (w_acc) begin
                r_core_din   <= w_acc_data;
                r_last_grant <= w_acc1;
            end
            if (w_tag_out.vld) begin
                if (w_tag_out.id) r_rsp1_data <= w_result;
                else              r_rsp0_data <= w_result;
            end
        end
    end

`ifdef CIPHER_STATS_EN
    logic [15:0] r_stat_jobs0;
    logic [15:0] r_stat_jobs1;
    logic [15:0] r_stat_keyloads;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_stat_jobs0    <= '0;
            r_stat_jobs1    <= '0;
            r_stat_keyloads <= '0;
        end else begin
            if (w_acc0 && (r_stat_jobs0 != '1)) r_stat_jobs0 <= r_stat_jobs0 + 16'd1;
            if (w_acc1 && (r_stat_jobs1 != '1)) r_stat_jobs1 <= r_stat_jobs1 + 16'd1;
            if ((r_state == DRAIN) && !w_tag_any && (r_stat_keyloads != '1))
                r_stat_keyloads <= r_stat_keyloads + 16'd1;
        end
    end

    assign stat_jobs0    = r_stat_jobs0;
    assign stat_jobs1    = r_stat_jobs1;
    assign stat_keyloads = r_stat_keyloads;
`endif

    assign bus.req0_ready   = w_rdy0;
    assign bus.req1_ready   = w_rdy1;
    assign bus.core_din     = r_core_din;
    assign bus.core_key     = r_core_key;
    assign bus.core_enc_vld = r_enc_vld;
    assign bus.core_dec_vld = r_dec_vld;
    assign bus.rsp0_valid   = r_rsp0_valid;
    assign bus.rsp0_data    = r_rsp0_data;
    assign bus.rsp1_valid   = r_rsp1_valid;
    assign bus.rsp1_data    = r_rsp1_data;
    assign bus.busy         = (r_state != IDLE) || w_tag_any;

endmodule

// File: doc/cipher_job_arbiter.md
Name: cipher_job_arbiter

Overview:
- Shares one encrypt core and one decrypt core (64-bit block, 128-bit key, shared key input) between two requesters, e.g. the VGA front end and a host/test port.
- Arbitrates requests round-robin and drives core data, key and valid strobes.
- Stalls for key reload when the key changes.
- Tracks in-flight jobs with a tag pipeline and routes each result back to its originating requester.

Parameters:
- LATENCY, 8: edges from a core sampling its valid strobe to its dout being valid for that block; range 1..32.
- KEY_SETUP, 2: idle cycles with the new key held on core_key before the first block using it is issued; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous reset, active-low
- reqN_valid  in  1  request valid (N=0,1)
- reqN_ready  out  1  request accepted this cycle (N=0,1)
- reqN_mode  in  1  0=encrypt, 1=decrypt
- reqN_data  in  64  input block
- reqN_key  in  128  key
- core_din  out  64  registered block to both cores
- core_key  out  128  registered key to both cores
- core_enc_vld  out  1  encrypt core di_vld
- core_dec_vld  out  1  decrypt core di_vld
- core_enc_dout  in  64  encrypt core result
- core_dec_dout  in  64  decrypt core result
- rspN_valid  out  1  one-cycle result pulse (N=0,1); no backpressure
- rspN_data  out  64  result block
- busy  out  1  state≠IDLE or any tag valid

Behaviour:
- Reset (clr=0, async): state=IDLE; all core outputs 0; cur_key=0; key_loaded=0; all tags invalid; rsp*_valid=0, rsp*_data=0; last_grant=1, so requester 0 wins the first tie.
- Grant (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the one not in last_grant is granted.
- reqN_ready=1 only when all of the following hold:
  - state=IDLE
  - N is granted
  - key_loaded=1
  - reqN_key==cur_key (full 128-bit compare)
- Accept is reqN_valid&&reqN_ready at edge T. On accept:
  - last_grant←N.
  - At edge T: core_din←reqN_data; core_{enc|dec}_vld←1 per mode (other strobe 0).
  - At edge T: tag stage0←{valid,N,mode}.
  - Strobes drop at T+1 unless another accept occurs.
- Throughput is one accept per cycle, alternating under contention.
- FSM:
  - IDLE → DRAIN: granted request with a key mismatch or key_loaded=0. No accept that cycle.
  - DRAIN: ready=0; wait until all tags are invalid, then → KEYSET with core_key←granted key latched at the IDLE→DRAIN decision (pending_key).
  - KEYSET: count KEY_SETUP cycles, then cur_key←pending_key, key_loaded←1, → IDLE.
  - If the requester withdraws valid during DRAIN/KEYSET, the key load still completes.
  - core_key changes only on the DRAIN→KEYSET edge.
- Tag pipeline:
  - LATENCY+1 stages; shifts every cycle.
  - When the final-stage tag is valid at edge E: rspN_valid←1 and rspN_data←(mode ? core_dec_dout : core_enc_dout) at edge E, where N=tag id.
  - Accept at edge T gives a response pulse in the cycle after edge T+LATENCY+1.
  - Responses leave in issue order; rsp0 and rsp1 are never valid in the same cycle.
- rspN_data holds its last value when valid is low.
- Reset mid-operation: in-flight tags discarded; no response emitted for them; key must be reloaded.
- busy=0 exactly when state=IDLE and no tag is valid.

Optional Feature:
- CIPHER_STATS_EN defined:
  - Adds outputs stat_jobs0[15:0], stat_jobs1[15:0]: saturating counts of accepts per requester.
  - Adds stat_keyloads[15:0]: saturating count of KEYSET entries.
  - All reset to 0.
- CIPHER_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cipher_ctrl_pkg holds:
  - BLK_W=64, KEY_W=128.
  - State enum {IDLE, DRAIN, KEYSET}.
  - Tag struct {vld, id, mode}.
- Sub-module cipher_tag_pipe: parameterised-depth tag shift register, async active-low clear, outputs the final stage plus an any-valid flag.

Test Plan (bench uses a stub core: dout = din XOR key[63:0], delayed LATENCY; LATENCY=4, KEY_SETUP=2):
- Reset, then req0 encrypt, din=0, key=128'h1 → DRAIN, KEYSET 2 cycles, accept; rsp0_valid one cycle with data 64'h1, exactly LATENCY+2 cycles after accept; busy then returns 0.
- Both requesters valid, same key 128'h1: req0 decrypt 64'heedba5216d8f4b15, req1 encrypt 0 → accepts alternate 0,1,0,1; responses in the same order; rsp0=64'heedba5216d8f4b14, rsp1=64'h1; no stall cycles.
- Key change mid-stream: 3 blocks with key 1 back-to-back, then key 2 → ready low until all 3 responses are out plus 2 KEYSET cycles; the next result uses key 2.
- Only req1 valid for 10 cycles → 10 consecutive accepts, 10 response pulses, no gaps.
- clr driven low while 3 jobs are in flight → outputs 0 immediately; no rsp pulses afterwards; next request triggers a key reload.
- With CIPHER_STATS_EN: 5 req0 jobs, 3 req1 jobs, 2 key changes → stat_jobs0=5, stat_jobs1=3, stat_keyloads=3.
